wspr_tone_sequencer: RTL and testbench
======================================

Name: wspr_tone_sequencer

Overview:
Sequences the NCO sin/cos generator for one WSPR transmission. Fetches 162 two-bit channel symbols from a synchronous symbol RAM and computes a 4-FSK frequency tuning word per symbol. Runs a phase-continuous 32-bit phase accumulator and drives the 20-bit angle into the sin/cos generator. Tracks that generator's pipeline latency so downstream logic gets a valid strobe aligned with sin/cos output.

Parameters:
NSYM, 162, symbols per transmission (>=2)
SYM_CYCLES, 8192, clock cycles per symbol (>=4)
SINCOS_LAT, 5, clock latency from angle input to sin/cos output of the generator
ADDR_W, 8, symbol RAM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a transmission when idle
abort  in  1  pulse; terminates a transmission immediately
base_ftw  in  32  tuning word of tone 0
tone_step  in  32  tuning-word spacing between adjacent tones
sym_addr  out  ADDR_W  symbol RAM read address
sym_data  in  2  symbol RAM read data, valid 1 cycle after sym_addr
angle  out  20  phase to sin/cos generator, equal to phase_acc[31:12]
angle_valid  out  1  angle carries active transmission phase
iq_valid  out  1  angle_valid delayed SINCOS_LAT cycles (aligned with sin/cos)
sym_strobe  out  1  1-cycle pulse on first RUN cycle of each symbol
busy  out  1  transmission in progress, including flush
done  out  1  1-cycle pulse on normal completion

Behaviour:
- Reset values: all outputs 0, phase_acc 0, state IDLE, delay line cleared.
- States: IDLE, PRIME0, PRIME1, RUN, FLUSH.
- IDLE: on start, latch base_ftw/tone_step into shadow registers, phase_acc<=0, sym_addr<=0, busy<=1, go to PRIME0. Later changes to the inputs are ignored until the next start.
- PRIME0: wait for RAM read latency. PRIME1: capture sym_data, set ftw = base + sym*step (mod 2^32), go to RUN. sym*step uses shift/add only: 0, step, step<<1, step+(step<<1).
- RUN: angle_valid=1. Each cycle phase_acc<=phase_acc+ftw. The angle on the first RUN cycle of a transmission is 0. Symbol counter cyc counts 0..SYM_CYCLES-1. sym_strobe=1 at cyc==0.
- Prefetch: at cyc==1, sym_addr<=index+1 (if not the last symbol). At cyc==3, capture ftw_next from sym_data.
- At cyc==SYM_CYCLES-1: if not the last symbol, ftw<=ftw_next, index++, cyc<=0. The phase is not reset, giving a phase-continuous tone switch. Each symbol lasts exactly SYM_CYCLES cycles.
- After the last cycle of symbol NSYM-1, go to FLUSH with angle_valid=0.
- FLUSH: count SINCOS_LAT cycles while the delay line drains. On the cycle after the last iq_valid=1, done=1, busy=0, go to IDLE.
- start while busy: ignored.
- abort (any non-IDLE state): next cycle state=IDLE, busy=0, angle_valid=0, delay line cleared so iq_valid=0, angle=0, no done. If abort and start arrive together in IDLE, start wins.
- rst mid-operation: same result as abort, and all outputs return to reset values.
- Total iq_valid high cycles per normal transmission = NSYM*SYM_CYCLES, contiguous.
- phase_acc wraps modulo 2^32 with no saturation.

Test Plan:
1. Assert rst for 3 cycles mid-RUN -> the next cycle has all outputs 0 and state IDLE. A following start runs normally from symbol 0.
2. NSYM=4, SYM_CYCLES=8, base=0x01000000, step=0x00100000, RAM={0,1,2,3} -> angle_valid high for 32 contiguous cycles. Angle on the first cycle of symbol 1 = 0x08000; on the first cycle of symbol 2 = 0x10800. sym_strobe fires 4 times, 8 cycles apart.
3. Same run -> iq_valid rises exactly 5 cycles after angle_valid and stays high 32 cycles. done pulses once, on the cycle after iq_valid falls, coincident with busy falling.
4. base=0x80000000, all symbols 0 -> angle alternates 0x00000, 0x80000 (wrap check). Pulsing start and changing base_ftw mid-run -> no effect on angle sequence.
5. abort at cycle 3 of symbol 2 -> next cycle busy=0, angle_valid=0, iq_valid=0, and done never asserts. Restart fetches sym_addr=0 first.
6. RAM symbol 3 with step=0xFFFFFFFF, base=0x00000003 -> ftw=0x00000000 (mod 2^32). Angle stays constant for that symbol.

Source files
------------

// File: rtl/wspr_tone_sequencer.sv
// WSPR 4-FSK tone sequencer: fetches channel symbols, runs a phase-continuous
// accumulator into the sin/cos generator, and tracks its latency for iq_valid.
module wspr_tone_sequencer #(
    parameter int NSYM       = 162,
    parameter int SYM_CYCLES = 8192,
    parameter int SINCOS_LAT = 5,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       base_ftw,
    input  logic [31:0]       tone_step,
    output logic [ADDR_W-1:0] sym_addr,
    input  logic [1:0]        sym_data,
    output logic [19:0]       angle,
    output logic              angle_valid,
    output logic              iq_valid,
    output logic              sym_strobe,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W = $clog2(SYM_CYCLES);
    localparam int FL_W  = (SINCOS_LAT > 1) ? $clog2(SINCOS_LAT) : 1;
    localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(SYM_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_SYM = ADDR_W'(NSYM - 1);
    localparam logic [FL_W-1:0]   LAST_FL  = FL_W'(SINCOS_LAT - 1);

    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, RUN, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] step;
    } tone_cfg_t;

    state_t              state, state_nx;
    tone_cfg_t           cfg;
    logic [31:0]         phase_acc;
    logic [31:0]         ftw;
    logic [31:0]         ftw_next;
    logic [31:0]         sym_ftw;
    logic [CYC_W-1:0]    cyc;
    logic [ADDR_W-1:0]   index;
    logic [FL_W-1:0]     flush_cnt;
    logic [SINCOS_LAT:1] vld_pipe;
    logic                kill;
    logic                last_cyc;
    logic                last_sym;

    assign kill     = abort && (state != IDLE);
    assign last_cyc = (cyc == LAST_CYC);
    assign last_sym = (index == LAST_SYM);

    assign angle       = phase_acc[31:12];
    assign angle_valid = (state == RUN);
    assign sym_strobe  = angle_valid && (cyc == '0);
    assign busy        = (state != IDLE);
    assign iq_valid    = vld_pipe[SINCOS_LAT];

    // Tone tuning word for the symbol on the RAM read port; multiply by 0..3 via shift/add.
    always_comb begin
        sym_ftw = cfg.base;
        case (sym_data)
            2'd1:    sym_ftw = cfg.base + cfg.step;
            2'd2:    sym_ftw = cfg.base + (cfg.step << 1);
            2'd3:    sym_ftw = cfg.base + cfg.step + (cfg.step << 1);
            default: sym_ftw = cfg.base;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PRIME0;
            PRIME0:  state_nx = PRIME1;
            PRIME1:  state_nx = RUN;
            RUN:     if (last_cyc && last_sym) state_nx = FLUSH;
            FLUSH:   if (flush_cnt == LAST_FL) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '0;
            phase_acc <= '0;
            ftw       <= '0;
            ftw_next  <= '0;
            cyc       <= '0;
            index     <= '0;
            flush_cnt <= '0;
            sym_addr  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cfg       <= '{base: base_ftw, step: tone_step};
                    phase_acc <= '0;
                    sym_addr  <= '0;
                    index     <= '0;
                    cyc       <= '0;
                    flush_cnt <= '0;
                end
                PRIME1: ftw <= sym_ftw;
                RUN: begin
                    phase_acc <= phase_acc + ftw;
                    if (cyc == CYC_W'(1) && !last_sym) sym_addr <= index + ADDR_W'(1);
                    if (cyc == CYC_W'(3)) ftw_next <= sym_ftw;
                    if (last_cyc) begin
                        cyc <= '0;
                        if (!last_sym) begin
                            // With 4-cycle symbols the prefetch lands on the switch cycle itself.
                            ftw   <= (cyc == CYC_W'(3)) ? sym_ftw : ftw_next;
                            index <= index + ADDR_W'(1);
                        end
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + FL_W'(1);
                    if (flush_cnt == LAST_FL) done <= 1'b1;
                end
                default: ;
            endcase
            if (kill) begin
                phase_acc <= '0;
                sym_addr  <= '0;
                done      <= 1'b0;
            end
        end
    end

    // Mirrors the sin/cos generator pipeline so iq_valid lines up with its output.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= angle_valid;
            for (int i = 2; i <= SINCOS_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

endmodule

// File: tb/tb_wspr_tone_sequencer.sv
// Scoreboard bench for wspr_tone_sequencer: per-cycle expected angle/strobe queue
// plus timing checks of valid, iq_valid, done and busy around each transmission.
module tb_wspr_tone_sequencer;
    localparam int NSYM = 4, SYM_CYCLES = 8, SINCOS_LAT = 5, ADDR_W = 8;
    localparam int L = NSYM * SYM_CYCLES;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [31:0]       base_ftw = '0, tone_step = '0;
    logic [ADDR_W-1:0] sym_addr;
    logic [1:0]        sym_data;
    logic [19:0]       angle;
    logic              angle_valid, iq_valid, sym_strobe, busy, done;

    wspr_tone_sequencer #(.NSYM(NSYM), .SYM_CYCLES(SYM_CYCLES), .SINCOS_LAT(SINCOS_LAT),
                          .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_ftw(base_ftw),
        .tone_step(tone_step), .sym_addr(sym_addr), .sym_data(sym_data), .angle(angle),
        .angle_valid(angle_valid), .iq_valid(iq_valid), .sym_strobe(sym_strobe),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    logic [1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) sym_data <= ram[sym_addr];

    typedef struct {
        logic [19:0] angle;
        logic        strobe;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0, n_fail = 0, cyc_n = 0;
    int av_cnt, iq_cnt, done_cnt, strobe_cnt, first_av, last_av, first_iq, last_iq;
    int done_cyc, busy_fall;
    logic prev_busy;
    logic [19:0] strobe_ang [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        av_cnt = 0; iq_cnt = 0; done_cnt = 0; strobe_cnt = 0;
        first_av = -1; last_av = -1; first_iq = -1; last_iq = -1;
        done_cyc = -1; busy_fall = -1; prev_busy = 1'b0;
    endtask

    task automatic set_ram(input logic [1:0] s0, s1, s2, s3);
        ram[0] = s0; ram[1] = s1; ram[2] = s2; ram[3] = s3;
    endtask

    // Drives start and pushes the reference angle/strobe sequence; k = first PRIME0 cycle.
    task automatic start_run(input logic [31:0] b, input logic [31:0] st, output int k);
        logic [31:0] ph, f;
        ph = '0;
        for (int s = 0; s < NSYM; s++) begin
            f = b + 32'(ram[s]) * st;
            for (int c = 0; c < SYM_CYCLES; c++) begin
                exp_q.push_back('{angle: ph[31:12], strobe: (c == 0)});
                ph = ph + f;
            end
        end
        start = 1'b1; base_ftw = b; tone_step = st;
        k = cyc_n + 1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_run(input int k);
        chk("first_av",  32'(first_av),  32'(k + 2));
        chk("av_cnt",    32'(av_cnt),    32'(L));
        chk("last_av",   32'(last_av),   32'(k + 1 + L));
        chk("first_iq",  32'(first_iq),  32'(k + 2 + SINCOS_LAT));
        chk("iq_cnt",    32'(iq_cnt),    32'(L));
        chk("last_iq",   32'(last_iq),   32'(k + 1 + L + SINCOS_LAT));
        chk("done_cnt",  32'(done_cnt),  32'd1);
        chk("done_cyc",  32'(done_cyc),  32'(k + 2 + L + SINCOS_LAT));
        chk("busy_fall", 32'(busy_fall), 32'(k + 2 + L + SINCOS_LAT));
        chk("strobes",   32'(strobe_cnt), 32'(NSYM));
        chk("q_empty",   32'(exp_q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Output monitor: pops the scoreboard on every active-phase cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (angle_valid) begin
                if (first_av < 0) first_av = cyc_n;
                last_av = cyc_n;
                av_cnt++;
                if (exp_q.size() == 0) begin
                    chk("angle_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("angle", 32'(angle), 32'(e.angle));
                    chk("strobe", 32'(sym_strobe), 32'(e.strobe));
                end
            end else begin
                chk("strobe_idle", 32'(sym_strobe), 32'd0);
            end
            if (iq_valid) begin
                if (first_iq < 0) first_iq = cyc_n;
                last_iq = cyc_n;
                iq_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            if (prev_busy && !busy) busy_fall = cyc_n;
            prev_busy = busy;
            if (sym_strobe) begin
                if (strobe_cnt < 16) strobe_ang[strobe_cnt] = angle;
                strobe_cnt++;
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 2'd0;
        clear_stats();

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_ctl", 32'({busy, done, angle_valid, iq_valid, sym_strobe}), 32'd0);
        chk("rst_angle", 32'(angle), 32'd0);
        chk("rst_addr", 32'(sym_addr), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Four tones, one per symbol
        set_ram(2'd0, 2'd1, 2'd2, 2'd3);
        clear_stats();
        start_run(32'h0100_0000, 32'h0010_0000, k);
        tick(L + 15);
        check_run(k);
        chk("sym1_angle", 32'(strobe_ang[1]), 32'h0_8000);
        chk("sym2_angle", 32'(strobe_ang[2]), 32'h1_0800);

        // Wrap at half-cycle tone; start/base changes mid-run must be ignored
        set_ram(2'd0, 2'd0, 2'd0, 2'd0);
        clear_stats();
        start_run(32'h8000_0000, 32'h0000_1000, k);
        tick(10);
        start = 1'b1; base_ftw = 32'h1234_5678; tone_step = 32'h0F0F_0F0F;
        tick(1);
        start = 1'b0;
        tick(L + 5);
        check_run(k);
        chk("wrap_sym1", 32'(strobe_ang[1]), 32'h0_0000);

        // Symbol 3 with an all-ones step folds the tuning word to zero
        set_ram(2'd1, 2'd3, 2'd2, 2'd3);
        clear_stats();
        start_run(32'h0000_0003, 32'hFFFF_FFFF, k);
        tick(L + 15);
        check_run(k);

        // Abort on cycle 3 of symbol 2
        set_ram(2'd0, 2'd1, 2'd2, 2'd3);
        clear_stats();
        start_run(32'h0100_0000, 32'h0010_0000, k);
        tick(2 + 2 * SYM_CYCLES + 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ctl", 32'({busy, angle_valid, iq_valid, done}), 32'd0);
        chk("abort_angle", 32'(angle), 32'd0);
        chk("abort_popped", 32'(av_cnt), 32'(2 * SYM_CYCLES + 4));
        chk("abort_left", 32'(exp_q.size()), 32'(L - 2 * SYM_CYCLES - 4));
        tick(12);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        clear_stats();
        start_run(32'h0200_0000, 32'h0008_0000, k);
        @(negedge clk);
        chk("restart_addr", 32'(sym_addr), 32'd0);
        tick(L + 15);
        check_run(k);

        // Reset held three cycles in the middle of a run
        clear_stats();
        start_run(32'h0100_0000, 32'h0010_0000, k);
        tick(12);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("mid_rst_ctl", 32'({busy, done, angle_valid, iq_valid, sym_strobe}), 32'd0);
        chk("mid_rst_angle", 32'(angle), 32'd0);
        chk("mid_rst_addr", 32'(sym_addr), 32'd0);
        @(posedge clk);
        #1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ctl", 32'({busy, done, angle_valid, iq_valid, sym_strobe}), 32'd0);
        chk("post_rst_angle", 32'(angle), 32'd0);
        tick(1);
        exp_q.delete();
        clear_stats();
        start_run(32'h0100_0000, 32'h0010_0000, k);
        tick(L + 15);
        check_run(k);
        chk("rst_run_sym1", 32'(strobe_ang[1]), 32'h0_8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
